// File: rtl/mage_pkg.sv
// Shared MAGE constants and the load/store configuration sequencer state encoding.
package mage_pkg;

  localparam int KMEM_SIZE       = 8;
  localparam int N_CFG_ADDR_BITS = $clog2(KMEM_SIZE);

  // Slot count at slot-count width, used to clamp oversize requests.
  localparam logic [N_CFG_ADDR_BITS:0] KMEM_SLOTS = KMEM_SIZE[N_CFG_ADDR_BITS:0];

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} ls_seq_state_t;

endpackage

// File: rtl/ls_seq_beat_counter.sv
// Loadable down-counter for beats within a slot; advances only on enabled (non-stalled) cycles
// and flags the last beat when it reaches zero.
module ls_seq_beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] L_ONE = 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt - L_ONE;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ls_stream_cfg_sequencer.sv
// Steps the L/S stream-select configuration slot address through n_slots slots, n_iter times.
// Optional stall cycle counter on stall_cnt_o when LS_SEQ_STALL_CNT_EN is defined.
module ls_stream_cfg_sequencer
  import mage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic                                 stall_i,
  input  logic [N_CFG_ADDR_BITS:0]             n_slots_i,
  input  logic [CNT_W-1:0]                     n_iter_i,
  input  logic [KMEM_SIZE-1:0][CNT_W-1:0]      slot_len_i,
  output logic [N_CFG_ADDR_BITS-1:0]           rcfg_ctrl_addr_o,
  output logic                                 cfg_valid_o,
  output logic                                 slot_switch_o,
  output logic                                 busy_o,
  output logic                                 done_o
`ifdef LS_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                          stall_cnt_o
`endif
);

  localparam logic [N_CFG_ADDR_BITS:0]   L_ONE_S = 1;
  localparam logic [N_CFG_ADDR_BITS-1:0] L_ONE_A = 1;
  localparam logic [CNT_W-1:0]           L_ONE_C = 1;

  // A programmed length of 0 still yields one beat; the counter holds beats-minus-one.
  function automatic logic [CNT_W-1:0] f_beats_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - L_ONE_C);
  endfunction

  ls_seq_state_t              r_state, w_state_nxt;
  logic [N_CFG_ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]           r_iter, w_iter_nxt;
  logic [N_CFG_ADDR_BITS:0]   r_n_slots, w_n_slots_nxt;
  logic [CNT_W-1:0]           r_n_iter, w_n_iter_nxt;
  logic                       r_valid, w_valid_nxt;
  logic                       r_switch, w_switch_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;

  logic                       w_bc_load, w_bc_en, w_bc_tc;
  logic [CNT_W-1:0]           w_bc_val;

  logic [N_CFG_ADDR_BITS:0]   w_ns_clamp;
  logic                       w_last_slot, w_last_iter;
  logic [N_CFG_ADDR_BITS-1:0] w_addr_inc;

  assign w_ns_clamp  = (n_slots_i > KMEM_SLOTS) ? KMEM_SLOTS : n_slots_i;
  assign w_last_slot = ({1'b0, r_addr} == (r_n_slots - L_ONE_S));
  assign w_last_iter = (r_iter == (r_n_iter - L_ONE_C));
  assign w_addr_inc  = r_addr + L_ONE_A;

  ls_seq_beat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_bc_load),
    .i_load_val (w_bc_val),
    .i_en       (w_bc_en),
    .o_tc       (w_bc_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= SEQ_IDLE;
      r_addr    <= '0;
      r_iter    <= '0;
      r_n_slots <= '0;
      r_n_iter  <= '0;
      r_valid   <= 1'b0;
      r_switch  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_iter    <= w_iter_nxt;
      r_n_slots <= w_n_slots_nxt;
      r_n_iter  <= w_n_iter_nxt;
      r_valid   <= w_valid_nxt;
      r_switch  <= w_switch_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_iter_nxt    = r_iter;
    w_n_slots_nxt = r_n_slots;
    w_n_iter_nxt  = r_n_iter;
    w_valid_nxt   = r_valid;
    w_switch_nxt  = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_bc_load     = 1'b0;
    w_bc_val      = '0;
    w_bc_en       = 1'b0;

    case (r_state)
      SEQ_IDLE: begin
        w_addr_nxt  = '0;
        w_iter_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start_i && !abort_i) begin
          w_busy_nxt = 1'b1;
          if ((w_ns_clamp == '0) || (n_iter_i == '0)) begin
            w_state_nxt = SEQ_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = SEQ_RUN;
            w_n_slots_nxt = w_ns_clamp;
            w_n_iter_nxt  = n_iter_i;
            w_valid_nxt   = 1'b1;
            w_switch_nxt  = 1'b1;
            w_bc_load     = 1'b1;
            w_bc_val      = f_beats_m1(slot_len_i[0]);
          end
        end
      end

      SEQ_RUN: begin
        if (abort_i) begin
          w_state_nxt = SEQ_IDLE;
          w_addr_nxt  = '0;
          w_iter_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_bc_load   = 1'b1;
        end else if (!stall_i) begin
          if (!w_bc_tc) begin
            w_bc_en = 1'b1;
          end else if (!w_last_slot) begin
            w_addr_nxt   = w_addr_inc;
            w_switch_nxt = 1'b1;
            w_bc_load    = 1'b1;
            w_bc_val     = f_beats_m1(slot_len_i[w_addr_inc]);
          end else if (!w_last_iter) begin
            w_addr_nxt   = '0;
            w_iter_nxt   = r_iter + L_ONE_C;
            w_switch_nxt = 1'b1;
            w_bc_load    = 1'b1;
            w_bc_val     = f_beats_m1(slot_len_i[0]);
          end else begin
            w_state_nxt = SEQ_DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_bc_load   = 1'b1;
          end
        end
      end

      SEQ_DONE: begin
        w_state_nxt = SEQ_IDLE;
        w_addr_nxt  = '0;
        w_iter_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = SEQ_IDLE;
        w_addr_nxt  = '0;
        w_iter_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign rcfg_ctrl_addr_o = r_addr;
  assign cfg_valid_o      = r_valid;
  assign slot_switch_o    = r_switch;
  assign busy_o           = r_busy;
  assign done_o           = r_done;

`ifdef LS_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Restarts with each new sequence and is left untouched afterwards so it can be read out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == SEQ_IDLE) && (w_state_nxt == SEQ_RUN)) begin
      r_stall_cnt <= '0;
    end else if ((r_state == SEQ_RUN) && stall_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ls_stream_cfg_sequencer.sv
// Scoreboard bench for ls_stream_cfg_sequencer: expected per-cycle slot address and switch
// pulses are queued when a sequence is launched and popped as the DUT presents valid cycles.
module tb_ls_stream_cfg_sequencer;
  import mage_pkg::*;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [N_CFG_ADDR_BITS-1:0] addr;
    logic                       sw;
  } exp_t;

  logic                              clk_i = 1'b0;
  logic                              rst_i;
  logic                              start_i;
  logic                              abort_i;
  logic                              stall_i;
  logic [N_CFG_ADDR_BITS:0]          n_slots_i;
  logic [CNT_W-1:0]                  n_iter_i;
  logic [KMEM_SIZE-1:0][CNT_W-1:0]   slot_len_i;
  logic [N_CFG_ADDR_BITS-1:0]        rcfg_ctrl_addr_o;
  logic                              cfg_valid_o;
  logic                              slot_switch_o;
  logic                              busy_o;
  logic                              done_o;
`ifdef LS_SEQ_STALL_CNT_EN
  logic [31:0]                       stall_cnt_o;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  ls_stream_cfg_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .stall_i          (stall_i),
    .n_slots_i        (n_slots_i),
    .n_iter_i         (n_iter_i),
    .slot_len_i       (slot_len_i),
    .rcfg_ctrl_addr_o (rcfg_ctrl_addr_o),
    .cfg_valid_o      (cfg_valid_o),
    .slot_switch_o    (slot_switch_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
`ifdef LS_SEQ_STALL_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launches one sequence and checks every cycle until a few cycles past its end.
  task automatic run_seq(input string tag, input int ns, input int ni,
                         input logic [KMEM_SIZE-1:0][CNT_W-1:0] lens,
                         input int stall_at, input int stall_n,
                         input int abort_at, input int busy_start_at);
    int   nse;
    int   total;
    int   nb;
    exp_t e;
    sb.delete();
    nse = (ns > KMEM_SIZE) ? KMEM_SIZE : ns;
    for (int it = 0; it < ni; it++) begin
      for (int s = 0; s < nse; s++) begin
        nb = (lens[s] == '0) ? 1 : int'(lens[s]);
        for (int b = 0; b < nb; b++) begin
          e.addr = N_CFG_ADDR_BITS'(s);
          e.sw   = (b == 0);
          sb.push_back(e);
        end
      end
    end
    if (stall_at >= 0 && stall_at < sb.size()) begin
      e    = sb[stall_at];
      e.sw = 1'b0;
      for (int k = 0; k < stall_n; k++) sb.insert(stall_at + 1, e);
    end
    if (abort_at >= 0) begin
      while (sb.size() > abort_at + 1) void'(sb.pop_back());
    end
    total = sb.size();

    @(posedge clk_i); #1;
    n_slots_i  = (N_CFG_ADDR_BITS+1)'(ns);
    n_iter_i   = CNT_W'(ni);
    slot_len_i = lens;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;

    for (int c = 0; c < total + 3; c++) begin
      stall_i = (stall_at >= 0 && c >= stall_at && c < stall_at + stall_n);
      abort_i = (c == abort_at);
      start_i = (c == busy_start_at);
      if (c == busy_start_at) n_slots_i = 1;
      @(negedge clk_i);
      if (c < total) begin
        e = sb.pop_front();
        check_val($sformatf("%s_addr_c%0d", tag, c), 32'(rcfg_ctrl_addr_o), 32'(e.addr));
        check_val($sformatf("%s_sw_c%0d", tag, c), 32'(slot_switch_o), 32'(e.sw));
        check_val($sformatf("%s_valid_c%0d", tag, c), 32'(cfg_valid_o), 32'd1);
        check_val($sformatf("%s_done_c%0d", tag, c), 32'(done_o), 32'd0);
      end else if (c == total && abort_at < 0) begin
        check_val($sformatf("%s_done_c%0d", tag, c), 32'(done_o), 32'd1);
        check_val($sformatf("%s_valid_c%0d", tag, c), 32'(cfg_valid_o), 32'd0);
        check_val($sformatf("%s_busy_c%0d", tag, c), 32'(busy_o), 32'd1);
      end else begin
        check_val($sformatf("%s_done_c%0d", tag, c), 32'(done_o), 32'd0);
        check_val($sformatf("%s_busy_c%0d", tag, c), 32'(busy_o), 32'd0);
        check_val($sformatf("%s_valid_c%0d", tag, c), 32'(cfg_valid_o), 32'd0);
        check_val($sformatf("%s_addr_c%0d", tag, c), 32'(rcfg_ctrl_addr_o), 32'd0);
      end
      @(posedge clk_i); #1;
    end
    stall_i = 1'b0;
    abort_i = 1'b0;
    start_i = 1'b0;
`ifdef LS_SEQ_STALL_CNT_EN
    if (total > 0) check_val({tag, "_stall_cnt"}, stall_cnt_o, 32'(stall_n));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KMEM_SIZE-1:0][CNT_W-1:0] lb;
    logic [KMEM_SIZE-1:0][CNT_W-1:0] l1;
    logic [KMEM_SIZE-1:0][CNT_W-1:0] l0;
    logic                            busy_pre;

    lb    = '0;
    lb[0] = 16'd2;
    lb[1] = 16'd1;
    lb[2] = 16'd3;
    l1    = '0;
    for (int i = 0; i < KMEM_SIZE; i++) l1[i] = 16'd1;
    l0    = '0;

    rst_i      = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    stall_i    = 1'b0;
    n_slots_i  = '0;
    n_iter_i   = '0;
    slot_len_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_addr",  32'(rcfg_ctrl_addr_o), 32'd0);
    check_val("rst_valid", 32'(cfg_valid_o),      32'd0);
    check_val("rst_sw",    32'(slot_switch_o),    32'd0);
    check_val("rst_busy",  32'(busy_o),           32'd0);
    check_val("rst_done",  32'(done_o),           32'd0);
`ifdef LS_SEQ_STALL_CNT_EN
    check_val("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif

    run_seq("base",    3, 2, lb, -1, 0, -1, -1);
    run_seq("stall",   3, 2, lb,  2, 4, -1, -1);
    run_seq("iter0",   3, 0, lb, -1, 0, -1, -1);
    run_seq("slots0",  0, 2, lb, -1, 0, -1, -1);
    run_seq("clamp",  12, 2, l1, -1, 0, -1, -1);
    run_seq("abort",   3, 2, lb, -1, 0, 11, -1);
    run_seq("busyst",  3, 2, lb, -1, 0, -1, 3);
    run_seq("len0",    4, 1, l0, -1, 0, -1, -1);

    @(posedge clk_i); #1;
    n_slots_i  = 3;
    n_iter_i   = 2;
    slot_len_i = lb;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    busy_pre = busy_o;
    check_val("midrst_pre_busy", 32'(busy_pre), 32'd1);
    check_val("midrst_pre_addr", 32'(rcfg_ctrl_addr_o), 32'd2);
    rst_i = 1'b1;
    #1;
    check_val("midrst_busy",  32'(busy_o),           32'd0);
    check_val("midrst_valid", 32'(cfg_valid_o),      32'd0);
    check_val("midrst_addr",  32'(rcfg_ctrl_addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run_seq("postrst", 3, 2, lb, -1, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
